l2_msg_merge: RTL and testbench

Parametrised N-channel message merge for the L2 NoC side. Each input channel (for example `l2_rsp_out` and `l2_fwd_out`, which carry identical fields) feeds its own FIFO. One arbiter drains the FIFOs onto a single valid/ready output plane and tags each beat with its source channel. It sits between `l2_core` outputs and the top-level flattened ports. It generalises the single-channel pass-through to any channel count, FIFO depth, payload width and arbitration mode.

---
 rtl/l2_msg_merge_pkg.sv | 8 +
 rtl/spandex_consts.sv | 4 +
 rtl/spandex_types.sv | 31 +++
 rtl/l2_merge_fifo.sv | 51 +++++
 rtl/l2_msg_merge.sv | 115 +++++++++++
 tb/tb_l2_msg_merge.sv | 237 +++++++++++++++++++++++
 6 files changed

// File: rtl/l2_msg_merge_pkg.sv
// Arbiter state encoding and channel-index width helper for l2_msg_merge.
package l2_msg_merge_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spandex_consts.sv
// Shared L2-side constants used as parameter defaults across the NoC glue.
package spandex_consts;
  localparam int L2_MERGE_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/spandex_types.sv
// Shared L2 message payload layout (256 bits) and its pack helper for rsp/fwd channels.
package spandex_types;
  typedef struct packed {
    logic [80:0]  pad;
    logic [4:0]   coh_msg;
    logic [4:0]   req_id;
    logic         to_req;
    logic [31:0]  addr;
    logic [127:0] line;
    logic [3:0]   word_mask;
  } l2_merge_msg_t;

  function automatic l2_merge_msg_t l2_merge_pack(
    input logic [4:0]   coh_msg,
    input logic [4:0]   req_id,
    input logic         to_req,
    input logic [31:0]  addr,
    input logic [127:0] line,
    input logic [3:0]   word_mask
  );
    l2_merge_msg_t m;
    m           = '0;
    m.coh_msg   = coh_msg;
    m.req_id    = req_id;
    m.to_req    = to_req;
    m.addr      = addr;
    m.line      = line;
    m.word_mask = word_mask;
    return m;
  endfunction
endpackage

// File: rtl/l2_merge_fifo.sv
// Per-channel circular FIFO; 1-cycle push-to-head latency, o_rdy from the registered count only.
module l2_merge_fifo #(
  parameter int DEPTH = 4,
  parameter int MSG_W = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [MSG_W-1:0] i_dat,
  input  logic             i_pop,
  output logic             o_rdy,
  output logic             o_vld,
  output logic [MSG_W-1:0] o_dat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [MSG_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses a push even while it pops in the same cycle.
  assign o_rdy  = (r_cnt != CW'(DEPTH));
  assign o_vld  = (r_cnt != '0);
  assign o_dat  = o_vld ? r_mem[r_rd] : '0;
  assign w_push = i_push && o_rdy;
  assign w_pop  = i_pop && o_vld;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/l2_msg_merge.sv
// N-channel message merge: per-channel FIFOs drained by a RR/fixed arbiter; in->out latency 1 cycle.
// Grant locks while out_ready is low; optional stall counters under L2_MERGE_STATS_EN.
module l2_msg_merge
  import spandex_consts::*;
  import l2_msg_merge_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DEPTH    = L2_MERGE_DEPTH_DEFAULT,
  parameter int MSG_W    = 256,
  parameter int ARB_MODE = 0,
  localparam int CH_W    = ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*MSG_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MSG_W-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch
`ifdef L2_MERGE_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]    stats_stall_cnt
`endif
);
  logic [NUM_CH-1:0] w_vld;
  logic [NUM_CH-1:0] w_pop;
  logic [MSG_W-1:0]  w_head [NUM_CH];
  arb_state_e        r_state;
  logic [CH_W-1:0]   r_grant;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   w_pick;
  logic [CH_W-1:0]   w_idx;
  logic [CH_W-1:0]   w_grant;
  logic [CH_W-1:0]   w_rr_nxt;
  logic              w_found;
  logic              w_hs;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    l2_merge_fifo #(.DEPTH(DEPTH), .MSG_W(MSG_W)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .i_push (in_valid[g]),
      .i_dat  (in_data[g*MSG_W +: MSG_W]),
      .i_pop  (w_pop[g]),
      .o_rdy  (in_ready[g]),
      .o_vld  (w_vld[g]),
      .o_dat  (w_head[g])
    );
    assign w_pop[g] = w_hs && (w_grant == CH_W'(g));
  end

  function automatic int arb_pos(input int ptr, input int i);
    return (ARB_MODE == 1) ? i : (ptr + i) % NUM_CH;
  endfunction

  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = CH_W'(arb_pos(int'(r_rr_ptr), i));
      if (!w_found && w_vld[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Once locked, the held grant wins even if a higher-priority channel fills.
  assign w_grant   = (r_state == ARB_LOCKED) ? r_grant : w_pick;
  assign out_valid = |w_vld;
  assign w_hs      = out_valid && out_ready;
  assign out_ch    = out_valid ? w_grant : '0;
  assign out_data  = out_valid ? w_head[w_grant] : '0;
  assign w_rr_nxt  = (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (out_valid && !out_ready) begin
            r_state <= ARB_LOCKED;
            r_grant <= w_pick;
          end
        end
        ARB_LOCKED: begin
          if (out_ready) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
      if (w_hs && ARB_MODE == 0) r_rr_ptr <= w_rr_nxt;
    end
  end

`ifdef L2_MERGE_STATS_EN
  logic [15:0] r_stall_cnt [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stats
    always_ff @(posedge clk) begin
      if (rst) begin
        r_stall_cnt[g] <= '0;
      end else if (in_valid[g] && !in_ready[g] && r_stall_cnt[g] != 16'hFFFF) begin
        r_stall_cnt[g] <= r_stall_cnt[g] + 16'd1;
      end
    end
    assign stats_stall_cnt[g*16 +: 16] = r_stall_cnt[g];
  end
`endif
endmodule

// File: tb/tb_l2_msg_merge.sv
// Bench for l2_msg_merge: round-robin and fixed-priority instances share stimulus and are
// scored every cycle against a queue-based model; directed phases check order, lock and wrap.
module tb_l2_msg_merge;
  localparam int NCH = 2;
  localparam int DEP = 4;
  localparam int W   = 256;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] in_valid;
  logic [NCH*W-1:0] in_data;
  logic           out_ready;
  logic [NCH-1:0] ir [2];
  logic           ov [2];
  logic [W-1:0]   od [2];
  logic           och [2];
`ifdef L2_MERGE_STATS_EN
  logic [NCH*16-1:0] st [2];
`endif

  always #5 clk = ~clk;

  l2_msg_merge #(.NUM_CH(NCH), .DEPTH(DEP), .MSG_W(W), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_ch(och[0])
`ifdef L2_MERGE_STATS_EN
    , .stats_stall_cnt(st[0])
`endif
  );

  l2_msg_merge #(.NUM_CH(NCH), .DEPTH(DEP), .MSG_W(W), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ch(och[1])
`ifdef L2_MERGE_STATS_EN
    , .stats_stall_cnt(st[1])
`endif
  );

  // Reference state: one message queue per (instance, channel).
  logic [W-1:0] q [2][NCH][$];
  logic [W-1:0] beats [2][$];
  int           rr [2];
  bit           lk [2];
  int           held [2];
  int           scnt [2][NCH];
  int           nchk = 0;
  int           nfail = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int m);
    if (lk[m]) return held[m];
    for (int i = 0; i < NCH; i++) begin
      int c = (m == 1) ? i : (rr[m] + i) % NCH;
      if (q[m][c].size() > 0) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NCH; c++) begin
        q[m][c].delete();
        scnt[m][c] = 0;
      end
      rr[m] = 0; lk[m] = 1'b0; held[m] = 0;
    end
  endtask

  task automatic model_clock();
    for (int m = 0; m < 2; m++) begin
      int g = pick(m);
      bit rdy [NCH];
      for (int c = 0; c < NCH; c++) rdy[c] = (q[m][c].size() != DEP);
      if (g >= 0 && out_ready) begin
        void'(q[m][g].pop_front());
        rr[m] = (g + 1) % NCH;
        lk[m] = 1'b0;
      end else if (g >= 0) begin
        lk[m] = 1'b1;
        held[m] = g;
      end
      for (int c = 0; c < NCH; c++) begin
        if (in_valid[c] && rdy[c]) q[m][c].push_back(in_data[c*W +: W]);
        if (in_valid[c] && !rdy[c] && scnt[m][c] < 16'hFFFF) scnt[m][c]++;
      end
    end
  endtask

  // Compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      int g = pick(m);
      logic [NCH-1:0] erdy;
      for (int c = 0; c < NCH; c++) erdy[c] = (q[m][c].size() != DEP);
      check($sformatf("out_valid[%0d]", m), W'(ov[m]), W'(g >= 0));
      check($sformatf("out_ch[%0d]", m), W'(och[m]), (g >= 0) ? W'(g) : '0);
      check($sformatf("out_data[%0d]", m), od[m], (g >= 0) ? q[m][g][0] : '0);
      check($sformatf("in_ready[%0d]", m), W'(ir[m]), W'(erdy));
`ifdef L2_MERGE_STATS_EN
      for (int c = 0; c < NCH; c++)
        check($sformatf("stall[%0d][%0d]", m, c), W'(st[m][c*16 +: 16]), W'(scnt[m][c]));
`endif
      if (ov[m] && out_ready) beats[m].push_back(od[m]);
    end
    @(posedge clk);
    if (rst) model_reset();
    else model_clock();
    #1;
  endtask

  task automatic rnd_data();
    for (int k = 0; k < NCH*W/32; k++) in_data[k*32 +: 32] = $urandom;
  endtask

  task automatic check_beats(input string tag, input int m, input logic [W-1:0] exp [$]);
    check({tag, "_len"}, W'(beats[m].size()), W'(exp.size()));
    for (int i = 0; i < exp.size() && i < beats[m].size(); i++)
      check($sformatf("%s_%0d", tag, i), beats[m][i], exp[i]);
  endtask

  logic [W-1:0] exp_q [$];
  logic [W-1:0] base;

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Reset held with all inputs valid: nothing may be queued.
    in_valid = 2'b11;
    rnd_data();
    repeat (2) step();
    rst = 1'b0; in_valid = '0;
    step();
    check("rst_out_valid", W'(ov[0]), '0);
    check("rst_in_ready", W'(ir[0]), W'(2'b11));
    check("rst_out_ch", W'(och[0]), '0);

    // Load A0..A2 on ch0 and B0..B2 on ch1, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 2'b11;
      in_data  = {W'(256'hB0 + i), W'(256'hA0 + i)};
      step();
    end
    in_valid = '0; out_ready = 1'b1;
    beats[0].delete(); beats[1].delete();
    repeat (7) step();
    base = 256'hA0;
    exp_q = '{base, base + 256'h10, base + 1, base + 256'h11, base + 2, base + 256'h12};
    check_beats("rr_order", 0, exp_q);
    exp_q = '{base, base + 1, base + 2, base + 256'h10, base + 256'h11, base + 256'h12};
    check_beats("fp_order", 1, exp_q);

    // Lock: ch1 waits, ch0 arrives later and must not preempt.
    out_ready = 1'b0;
    beats[0].delete(); beats[1].delete();
    in_valid = 2'b10; in_data = {W'(256'hC0C0), W'(0)};
    step();
    in_valid = '0;
    repeat (5) step();
    in_valid = 2'b01; in_data = {W'(0), W'(256'hD0D0)};
    step();
    in_valid = '0;
    repeat (2) step();
    check("lock_ch_rr", W'(och[0]), W'(1));
    check("lock_dat_rr", od[0], 256'hC0C0);
    check("lock_ch_fp", W'(och[1]), W'(1));
    check("lock_dat_fp", od[1], 256'hC0C0);
    out_ready = 1'b1;
    repeat (3) step();
    exp_q = '{256'hC0C0, 256'hD0D0};
    check_beats("lock_rr", 0, exp_q);
    check_beats("lock_fp", 1, exp_q);

    // Fill ch0, push during the draining pop (refused), drain, then 6 more through the wrap.
    out_ready = 1'b0;
    beats[0].delete(); beats[1].delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 2'b01; in_data = {W'(0), W'(256'hE0 + i)};
      step();
    end
    check("full_in_ready0", W'(ir[0][0]), '0);
    out_ready = 1'b1; in_valid = 2'b01; in_data = {W'(0), W'(256'hF0F0)};
    step();
    in_valid = '0;
    repeat (3) step();
    for (int i = 0; i < 6; i++) begin
      in_valid = 2'b01; in_data = {W'(0), W'(256'h60 + i)};
      step();
    end
    in_valid = '0;
    step();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(W'(256'hE0 + i));
    for (int i = 0; i < 6; i++) exp_q.push_back(W'(256'h60 + i));
    check_beats("wrap", 0, exp_q);

    // Random traffic with occasional mid-stream resets.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = NCH'($urandom);
      rnd_data();
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0;

`ifdef L2_MERGE_STATS_EN
    rst = 1'b1; in_valid = '0;
    step();
    rst = 1'b0; out_ready = 1'b0;
    in_valid = 2'b01;
    repeat (4) step();
    repeat (10) step();
    check("stall_10", W'(st[0][15:0]), W'(10));
    dut0.r_stall_cnt[0] = 16'hFFFD;
    dut1.r_stall_cnt[0] = 16'hFFFD;
    scnt[0][0] = 16'hFFFD;
    scnt[1][0] = 16'hFFFD;
    repeat (5) step();
    check("stall_sat", W'(st[0][15:0]), W'(16'hFFFF));
    in_valid = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
